// File: rtl/alsu_pkg.sv
// Shared definitions for the alsu pin driver: opcodes, FSM states, latched request
// record and the invalid-opcode decode.
package alsu_pkg;

    localparam logic [2:0] OP_OR     = 3'd0;
    localparam logic [2:0] OP_XOR    = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_MULT   = 3'd3;
    localparam logic [2:0] OP_SHIFT  = 3'd4;
    localparam logic [2:0] OP_ROTATE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRELOAD = 3'd1,
        S_APPLY   = 3'd2,
        S_DRAIN   = 3'd3,
        S_CAPTURE = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] a;
        logic [2:0] b;
        logic       cin;
        logic       serial_in;
        logic       direction;
        logic       red_op_a;
        logic       red_op_b;
        logic       bypass_a;
        logic       bypass_b;
    } req_t;

    // Reduction ops are only legal on OR/XOR; opcodes 6 and 7 are never legal.
    function automatic logic is_invalid(input logic [2:0] opcode,
                                        input logic       red_a,
                                        input logic       red_b);
        return ((red_a | red_b) & (opcode[1] | opcode[2])) | (opcode[1] & opcode[2]);
    endfunction

endpackage

// File: rtl/alsu_driver.sv
// Initiator for one alsu instance: takes a request, drives the alsu pins for an optional
// preload cycle plus reps command cycles, waits out the pipeline and returns out/leds.
module alsu_driver
    import alsu_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int REPS_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_opcode,
    input  logic [2:0]        req_a,
    input  logic [2:0]        req_b,
    input  logic              req_cin,
    input  logic              req_serial_in,
    input  logic              req_direction,
    input  logic              req_red_op_a,
    input  logic              req_red_op_b,
    input  logic              req_bypass_a,
    input  logic              req_bypass_b,
    input  logic              req_preload,
    input  logic [REPS_W-1:0] req_reps,
    output logic [2:0]        alsu_A,
    output logic [2:0]        alsu_B,
    output logic              alsu_cin,
    output logic              alsu_serial_in,
    output logic              alsu_red_op_A,
    output logic              alsu_red_op_B,
    output logic [2:0]        alsu_opcode,
    output logic              alsu_bypass_A,
    output logic              alsu_bypass_B,
    output logic              alsu_direction,
    input  logic [5:0]        alsu_out,
    input  logic [15:0]       alsu_leds,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [5:0]        resp_out,
    output logic [15:0]       resp_leds,
    output logic              resp_invalid
);

    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int CNT_W = (REPS_W > LAT_W) ? REPS_W : LAT_W;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    state_t           r_state, w_next;
    req_t             r_req, w_req;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_reps_m1;
    logic [CNT_W-1:0] w_req_reps_m1;
    logic [5:0]       r_resp_out;
    logic [15:0]      r_resp_leds;
    logic             r_resp_invalid;
    logic             w_accept;

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign w_accept   = req_valid && req_ready;

    // reps of 0 behaves as 1; counter holds remaining cycles minus one
    assign w_req_reps_m1 = (req_reps == '0) ? '0 : CNT_W'(req_reps - REPS_W'(1));

    assign w_req = '{opcode:    req_opcode,
                     a:         req_a,
                     b:         req_b,
                     cin:       req_cin,
                     serial_in: req_serial_in,
                     direction: req_direction,
                     red_op_a:  req_red_op_a,
                     red_op_b:  req_red_op_b,
                     bypass_a:  req_bypass_a,
                     bypass_b:  req_bypass_b};

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next    = req_preload ? S_PRELOAD : S_APPLY;
                    w_cnt_nxt = w_req_reps_m1;
                end
            end
            S_PRELOAD: begin
                w_next    = S_APPLY;
                w_cnt_nxt = r_reps_m1;
            end
            S_APPLY: begin
                if (r_cnt == '0) begin
                    if (LATENCY > 1) begin
                        w_next    = S_DRAIN;
                        w_cnt_nxt = DRAIN_LOAD;
                    end else begin
                        w_next = S_CAPTURE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (r_cnt == '0) w_next = S_CAPTURE;
                else             w_cnt_nxt = r_cnt - CNT_W'(1);
            end
            S_CAPTURE: w_next = S_RESP;
            S_RESP:    if (resp_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_req     <= '0;
            r_reps_m1 <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_req     <= w_req;
                r_reps_m1 <= w_req_reps_m1;
            end
        end
    end

    // CAPTURE sits exactly LATENCY cycles after the last APPLY cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_out     <= '0;
            r_resp_leds    <= '0;
            r_resp_invalid <= 1'b0;
        end else if (r_state == S_CAPTURE) begin
            r_resp_out     <= alsu_out;
            r_resp_leds    <= alsu_leds;
            r_resp_invalid <= is_invalid(r_req.opcode, r_req.red_op_a, r_req.red_op_b);
        end
    end

    assign resp_out     = r_resp_out;
    assign resp_leds    = r_resp_leds;
    assign resp_invalid = r_resp_invalid;

    // Pins are decoded straight from state so the alsu sees them in the same cycle.
    always_comb begin
        alsu_opcode    = OP_OR;
        alsu_A         = '0;
        alsu_B         = '0;
        alsu_cin       = 1'b0;
        alsu_serial_in = 1'b0;
        alsu_direction = 1'b0;
        alsu_red_op_A  = 1'b0;
        alsu_red_op_B  = 1'b0;
        alsu_bypass_A  = 1'b0;
        alsu_bypass_B  = 1'b0;
        case (r_state)
            S_PRELOAD: begin
                alsu_bypass_A = 1'b1;
                alsu_A        = r_req.a;
            end
            S_APPLY: begin
                alsu_opcode    = r_req.opcode;
                alsu_A         = r_req.a;
                alsu_B         = r_req.b;
                alsu_cin       = r_req.cin;
                alsu_serial_in = r_req.serial_in;
                alsu_direction = r_req.direction;
                alsu_red_op_A  = r_req.red_op_a;
                alsu_red_op_B  = r_req.red_op_b;
                alsu_bypass_A  = r_req.bypass_a;
                alsu_bypass_B  = r_req.bypass_b;
            end
            default: ;
        endcase
    end

endmodule
